xdisp_scan_ctrl: RTL and testbench
==================================

// Module: xdisp_scan_ctrl
// PURPOSE
//  Memory-mapped scan controller for the 4-digit 7-segment display. The CPU writes a 16-bit hex
//  value and control bits over the data bus (sel/we/addr/data_in, decoded by xaddr_decoder).
//  The block time-multiplexes the digits with an anti-ghosting blank gap.
//  Value updates are applied only at frame boundaries, so the display never tears.
// PARAMETERS
//  DATA_W       32     data bus width
//  REFRESH_CYC  50000  clock cycles per digit slot (gap + drive); must be > GAP_CYC
//  GAP_CYC      16     blank cycles at start of each slot (all digits off)
//  CNT_W        16     slot counter width; 2**CNT_W > REFRESH_CYC
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, ACTIVE-LOW (rst==0 resets)
//  sel         in   1       block select from address decoder
//  we          in   1       write enable (qualified by sel)
//  addr        in   2       register index
//  data_in     in   DATA_W  write data
//  data_out    out  DATA_W  read data; 0 when !sel or we
//  disp_sel    out  4       digit enables, active-low, [0] = rightmost digit
//  disp_value  out  8       segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Registers: 0 VALUE (w: pending[15:0], r: pending); 1 CTRL [0]=en [7:4]=dp_mask [11:8]=blank_mask;
//   2 STATUS (ro) [0]=pending_valid [2:1]=cur_digit [3]=en; 3 BRIGHT (see CONFIGURATION).
//  Reset: pending=shadow=0, pending_valid=0, CTRL=0, cnt=0, digit=0, disp_sel=4'hF, disp_value=8'hFF.
//  Reads combinational, zero latency; writes take effect on the next clk edge.
//  FSM OFF: en=0; outputs 4'hF/8'hFF, cnt and digit held at 0; a VALUE write copies to shadow next cycle.
//  OFF->GAP when en rises; GAP to DRIVE at cnt==GAP_CYC; DRIVE to GAP at cnt==REFRESH_CYC-1.
//   On that edge, cnt=0 and digit=digit+1 mod 4.
//  GAP: disp_sel=4'hF, disp_value=8'hFF. DRIVE: disp_sel=~(1<<digit), disp_value=seg(shadow nibble digit).
//   dp segment is driven low iff dp_mask[digit]. If blank_mask[digit], disp_sel=4'hF for the slot.
//  en cleared in any state: next cycle is OFF, outputs blank, cnt=digit=0.
//  Frame boundary = digit 3->0 wrap. There, if pending_valid: shadow<=pending, pending_valid<=0.
//  VALUE write sets pending_valid=1. A write in the boundary cycle: shadow takes the OLD pending;
//   the new data is stored and pending_valid stays 1.
//  Segment map (active-low, dp=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//   A=88 b=83 C=C6 d=A1 E=86 F=8E.
//  Reset asserted mid-frame: outputs blank immediately (async), all state cleared.
//  Write to STATUS ignored. Only data_in[15:0] (VALUE) and data_in[11:0] (CTRL) are used.
// CONFIGURATION
//  DISP_BRIGHT_EN defined: reg 3 BRIGHT[3:0], reset 4'hF. A free-running 4-bit pwm counter runs.
//   In DRIVE, the digit is enabled only when pwm<=BRIGHT, else disp_sel=4'hF. BRIGHT=F: always on.
//  DISP_BRIGHT_EN undefined: reg 3 reads 0, writes ignored, DRIVE always full on.
// TESTING (REFRESH_CYC=8, GAP_CYC=2)
//  Reset, en=0 -> disp_sel=F, disp_value=FF, data_out=0 for 20 cycles.
//  Write VALUE=16'h1234, CTRL=1 -> digit0 slot: 2 cycles F/FF, 6 cycles disp_sel=E, disp_value=99('4').
//   Then digit1: D/B0, digit2: B/A4, digit3: 7/F9; period 32 cycles.
//  Running, write VALUE=16'hABCD mid-digit1 -> digits 1-3 still show 3,2,1.
//   STATUS[0]=1 until the wrap; from next digit0, shows 'D'(A1). STATUS[0]=0.
//  CTRL=0x0201 (dp_mask=0, blank_mask=0010) -> digit1 slot disp_sel=F.
//   CTRL=0x0011 -> digit0 disp_value=19 ('4'+dp).
//  Clear en mid DRIVE of digit2 -> next cycle F/FF, STATUS[2:1]=0. Re-enable restarts at digit0 GAP.
//  rst=0 for 1 cycle mid-frame -> all outputs at reset values asynchronously. VALUE read = 0.
//  DISP_BRIGHT_EN, BRIGHT=3 -> in DRIVE, disp_sel active 4 of every 16 pwm cycles.

Source files
------------

// File: rtl/xdisp_scan_ctrl_if.sv
// CPU data-bus port of the display scan controller: select, write strobe, register index, write/read data.
interface xdisp_scan_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              sel;
   logic              we;
   logic [1:0]        addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport master (output sel, we, addr, data_in, input data_out);
   modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xdisp_scan_ctrl.sv
// 4-digit 7-segment scan controller with blank gap per slot and frame-boundary value update; DISP_BRIGHT_EN adds PWM brightness.
// Reads are combinational, writes land on the next clk edge; the bus is never stalled.
module xdisp_scan_ctrl #(
   parameter int DATA_W      = 32,
   parameter int REFRESH_CYC = 50000,
   parameter int GAP_CYC     = 16,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   xdisp_scan_ctrl_if.slave    bus,
   output logic [3:0]          disp_sel,
   output logic [7:0]          disp_value
);
   typedef enum logic [1:0] {ST_OFF, ST_GAP, ST_DRIVE} state_t;

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       digit, digit_nxt;
   logic [15:0]      pending, shadow;
   logic             pending_valid;
   logic             ctrl_en;
   logic [3:0]       dp_mask, blank_mask;
   logic             wr_value, wr_ctrl, en_nxt, slot_end, frame_wrap;
   logic [3:0]       nib;
   logic [6:0]       seg;
   logic             drive_on;
   logic [3:0]       bright_rd;

   assign wr_value   = bus.sel && bus.we && (bus.addr == 2'd0);
   assign wr_ctrl    = bus.sel && bus.we && (bus.addr == 2'd1);
   // Scanning follows the enable value that will hold after this edge.
   assign en_nxt     = wr_ctrl ? bus.data_in[0] : ctrl_en;
   assign frame_wrap = slot_end && (digit == 2'd3);
   assign nib        = shadow[{digit, 2'b00} +: 4];

`ifdef DISP_BRIGHT_EN
   logic       wr_bright;
   logic [3:0] bright, pwm;
   assign wr_bright = bus.sel && bus.we && (bus.addr == 2'd3);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bright <= 4'hF;
         pwm    <= 4'h0;
      end else begin
         pwm <= pwm + 4'd1;
         if (wr_bright) bright <= bus.data_in[3:0];
      end
   end
   assign drive_on  = (pwm <= bright);
   assign bright_rd = bright;
`else
   assign drive_on  = 1'b1;
   assign bright_rd = 4'h0;
`endif

   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_OFF;
         cnt   <= '0;
         digit <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         digit <= digit_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      digit_nxt  = digit;
      slot_end   = 1'b0;
      disp_sel   = 4'hF;
      disp_value = 8'hFF;
      unique case (state)
         ST_OFF: begin
            if (en_nxt) state_nxt = ST_GAP;
         end
         ST_GAP: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == GAP_LAST) state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            disp_value = {~dp_mask[digit], seg};
            if (!blank_mask[digit] && drive_on) disp_sel = ~(4'b0001 << digit);
            if (cnt == SLOT_LAST) begin
               slot_end  = 1'b1;
               cnt_nxt   = '0;
               digit_nxt = digit + 2'd1;
               state_nxt = ST_GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = ST_OFF;
      endcase
      if (!en_nxt) begin
         state_nxt = ST_OFF;
         cnt_nxt   = '0;
         digit_nxt = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending       <= 16'h0;
         shadow        <= 16'h0;
         pending_valid <= 1'b0;
         ctrl_en       <= 1'b0;
         dp_mask       <= 4'h0;
         blank_mask    <= 4'h0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en    <= bus.data_in[0];
            dp_mask    <= bus.data_in[7:4];
            blank_mask <= bus.data_in[11:8];
         end
         if (state == ST_OFF) begin
            // Nothing is being scanned, so the value can go straight to the display copy.
            shadow        <= wr_value ? bus.data_in[15:0] : pending;
            pending_valid <= 1'b0;
            if (wr_value) pending <= bus.data_in[15:0];
         end else begin
            if (frame_wrap && pending_valid) begin
               shadow        <= pending;
               pending_valid <= 1'b0;
            end
            if (wr_value) begin
               pending       <= bus.data_in[15:0];
               pending_valid <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.data_out = '0;
      if (bus.sel && !bus.we) begin
         case (bus.addr)
            2'd0:    bus.data_out = DATA_W'(pending);
            2'd1:    bus.data_out = DATA_W'({blank_mask, dp_mask, 3'b000, ctrl_en});
            2'd2:    bus.data_out = DATA_W'({ctrl_en, digit, pending_valid});
            default: bus.data_out = DATA_W'(bright_rd);
         endcase
      end
   end
endmodule

// File: tb/tb_xdisp_scan_ctrl.sv
// Randomised scoreboard bench for xdisp_scan_ctrl: a cycle-time model derived from elapsed scan time feeds expectation queues.
`timescale 1ns/1ps
module tb_xdisp_scan_ctrl;
   localparam int DATA_W  = 32;
   localparam int REFRESH = 8;
   localparam int GAP     = 2;
   localparam int CNT_W   = 4;
   localparam int FRAME   = 4 * REFRESH;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] disp_sel;
   logic [7:0] disp_value;

   xdisp_scan_ctrl_if #(.DATA_W(DATA_W)) bus ();

   xdisp_scan_ctrl #(.DATA_W(DATA_W), .REFRESH_CYC(REFRESH), .GAP_CYC(GAP), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .disp_sel   (disp_sel),
      .disp_value (disp_value)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference state: m_t counts cycles since scanning was (re)enabled.
   logic        m_en, m_pv;
   int          m_t;
   logic [15:0] m_pend, m_shadow;
   logic [3:0]  m_dp, m_bl, m_bright, m_pwm;

   logic [11:0] exp_disp [$];
   logic [31:0] exp_rd   [$];

   function automatic int cur_digit();
      return m_en ? (m_t / REFRESH) % 4 : 0;
   endfunction

   function automatic logic [11:0] model_out();
      int         d;
      logic [7:0] v;
      logic [3:0] s;
      logic [3:0] n;
      if (!m_en || (m_t % REFRESH) < GAP) return 12'hFFF;
      d    = cur_digit();
      n    = 4'((m_shadow >> (4 * d)) & 16'hF);
      v    = seg_tbl[n];
      v[7] = ~m_dp[d];
      s    = (!m_bl[d] && (m_pwm <= m_bright)) ? ~(4'b0001 << d) : 4'hF;
      return {s, v};
   endfunction

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {16'h0, m_pend};
         2'd1:    return {20'h0, m_bl, m_dp, 3'b000, m_en};
         2'd2:    return {28'h0, m_en, 2'(cur_digit()), m_pv};
`ifdef DISP_BRIGHT_EN
         default: return {28'h0, m_bright};
`else
         default: return 32'h0;
`endif
      endcase
   endfunction

   task automatic model_reset();
      m_en = 1'b0; m_pv = 1'b0; m_t = 0; m_pend = 16'h0; m_shadow = 16'h0;
      m_dp = 4'h0; m_bl = 4'h0; m_bright = 4'hF; m_pwm = 4'h0;
   endtask

   task automatic model_step();
      logic        wv, wc, wrap, new_en;
      logic [31:0] d;
      wv     = bus.sel && bus.we && (bus.addr == 2'd0);
      wc     = bus.sel && bus.we && (bus.addr == 2'd1);
      d      = bus.data_in;
      wrap   = m_en && ((m_t % FRAME) == FRAME - 1);
      new_en = wc ? d[0] : m_en;
      if (!m_en) begin
         if (wv) m_pend = d[15:0];
         m_shadow = m_pend;
         m_pv     = 1'b0;
      end else begin
         if (wrap && m_pv) begin m_shadow = m_pend; m_pv = 1'b0; end
         if (wv) begin m_pend = d[15:0]; m_pv = 1'b1; end
      end
      if (wc) begin m_dp = d[7:4]; m_bl = d[11:8]; end
`ifdef DISP_BRIGHT_EN
      if (bus.sel && bus.we && (bus.addr == 2'd3)) m_bright = d[3:0];
`endif
      m_t   = (m_en && new_en) ? m_t + 1 : 0;
      m_en  = new_en;
      m_pwm = m_pwm + 4'd1;
   endtask

   // Model: advance on each edge, queue what the DUT must show in the following cycle.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_reset(); else model_step();
         exp_disp.push_back(model_out());
         #2;
         if (rst && bus.sel && !bus.we) exp_rd.push_back(model_rd(bus.addr));
      end
   end

   // Monitor: compare on the falling edge, away from the active edge.
   initial begin
      logic [11:0] e;
      logic [31:0] r;
      forever begin
         @(negedge clk);
         checks++;
         if (exp_disp.size() == 0) begin
            fails++;
            $display("FAIL disp_queue_empty at %0t", $time);
         end else begin
            e = exp_disp.pop_front();
            if (!rst) e = 12'hFFF;
            if ({disp_sel, disp_value} !== e) begin
               fails++;
               $display("FAIL display at %0t: got sel=%h val=%h, want sel=%h val=%h",
                        $time, disp_sel, disp_value, e[11:8], e[7:0]);
            end
         end
         checks++;
         if (rst && bus.sel && !bus.we) begin
            if (exp_rd.size() == 0) begin
               fails++;
               $display("FAIL read_queue_empty at %0t", $time);
            end else begin
               r = exp_rd.pop_front();
               if (bus.data_out !== r) begin
                  fails++;
                  $display("FAIL read addr=%0d at %0t: got %h, want %h", bus.addr, $time, bus.data_out, r);
               end
            end
         end else if (bus.data_out !== 32'h0) begin
            fails++;
            $display("FAIL idle_read at %0t: got %h, want 0", $time, bus.data_out);
         end
      end
   end

   task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.sel = s; bus.we = w; bus.addr = a; bus.data_in = d;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'($urandom), 2'($urandom), $urandom);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [1:0] a);
      cyc(1'b1, 1'b0, a, $urandom);
   endtask

   task automatic wait_phase(input int ph);
      for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != ph; k++) idle(1);
   endtask

   initial begin
      int r;
      logic [31:0] d;
      bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.data_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         if (i % 4 == 0) rd(2'(i / 4)); else idle(1);
      end

      wr(2'd0, 32'h1234);
      wr(2'd1, 32'h1);
      for (int i = 0; i < 70; i++) begin
         if (i % 9 == 0) rd(2'd2); else idle(1);
      end

      wait_phase(12);
      wr(2'd0, 32'hFFFF_ABCD);
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0) rd(2'd2); else if (i % 7 == 0) rd(2'd0); else idle(1);
      end

      wr(2'd1, 32'h0201); idle(40); rd(2'd1);
      wr(2'd1, 32'h0011); idle(40);

      wr(2'd1, 32'h1);
      wait_phase(19);
      wr(2'd1, 32'h0);
      rd(2'd2); idle(5);
      wr(2'd1, 32'h1); idle(40);

      idle(13);
      @(posedge clk); #1;
      rst = 1'b0; bus.sel = 1'b0; bus.we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      rd(2'd0); rd(2'd1); rd(2'd2);
      wr(2'd0, $urandom); wr(2'd1, 32'h1); idle(30);

      wr(2'd3, 32'h3); idle(64); rd(2'd3);
      wr(2'd3, $urandom); idle(32); rd(2'd3);
      wr(2'd3, 32'hF);

      for (int i = 0; i < 700; i++) begin
         r = $urandom_range(0, 11);
         d = $urandom;
         case (r)
            0, 1:    wr(2'd0, d);
            2:       wr(2'd1, (d[2:0] == 3'd0) ? d : (d | 32'h1));
            3:       wr(2'd2, d);
            4:       wr(2'd3, d);
            5, 6, 7: rd(2'(d[1:0]));
            default: idle(1);
         endcase
      end

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
